// File: rtl/vga_ctrl.sv
// VGA raster timing generator: free-running h/v counters on pclk, with active-low
// syncs, an active-region flag, frame-buffer addresses and gated RGB output.
module vga_ctrl #(
    parameter int h_size  = 640,
    parameter int v_size  = 480,
    parameter int h_sync  = 96,
    parameter int h_back  = 48,
    parameter int h_front = 16,
    parameter int v_sync  = 2,
    parameter int v_back  = 33,
    parameter int v_front = 10
) (
    input  logic                        pclk,
    input  logic                        reset,
    input  logic [23:0]                 vga_data,
    output logic [$clog2(h_size)-1:0]   h_addr,
    output logic [$clog2(v_size)-1:0]   v_addr,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        valid,
    output logic [7:0]                  vga_r,
    output logic [7:0]                  vga_g,
    output logic [7:0]                  vga_b
);

    localparam int H_TOTAL = h_sync + h_back + h_size + h_front;
    localparam int V_TOTAL = v_sync + v_back + v_size + v_front;
    localparam int HW      = $clog2(h_size);
    localparam int VW      = $clog2(v_size);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0] H_LAST     = HCW'(H_TOTAL - 1);
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(h_sync);
    localparam logic [HCW-1:0] HA0        = HCW'(h_sync + h_back);
    localparam logic [HCW-1:0] HA1        = HCW'(h_sync + h_back + h_size);

    localparam logic [VCW-1:0] V_LAST     = VCW'(V_TOTAL - 1);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(v_sync);
    localparam logic [VCW-1:0] VA0        = VCW'(v_sync + v_back);
    localparam logic [VCW-1:0] VA1        = VCW'(v_sync + v_back + v_size);

    logic [HCW-1:0] h_cnt;
    logic [VCW-1:0] v_cnt;
    logic           h_active;
    logic           v_active;

    always_ff @(posedge pclk) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            // v advances only on the line wrap; both wrap together at frame end
            if (v_cnt == V_LAST) begin
                v_cnt <= '0;
            end else begin
                v_cnt <= v_cnt + VCW'(1);
            end
        end else begin
            h_cnt <= h_cnt + HCW'(1);
        end
    end

    always_comb begin
        h_active = (h_cnt >= HA0) && (h_cnt < HA1);
        v_active = (v_cnt >= VA0) && (v_cnt < VA1);
        hsync    = (h_cnt >= H_SYNC_END);
        vsync    = (v_cnt >= V_SYNC_END);
        valid    = h_active && v_active;
        h_addr   = h_active ? HW'(h_cnt - HA0) : '0;
        v_addr   = v_active ? VW'(v_cnt - VA0) : '0;
        // memory read is asynchronous, so the data belongs to this cycle's address
        {vga_r, vga_g, vga_b} = valid ? vga_data : 24'h0;
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: default-timing instance plus a tiny-timing instance so frame
// wraps are reached quickly; both are checked every cycle against a time-based model.
module tb_vga_ctrl;

    logic        pclk = 1'b0;
    logic        reset;
    logic [23:0] data_a, data_b;

    logic [9:0]  h_addr_a;
    logic [8:0]  v_addr_a;
    logic        hsync_a, vsync_a, valid_a;
    logic [7:0]  r_a, g_a, b_a;

    logic [2:0]  h_addr_b;
    logic [1:0]  v_addr_b;
    logic        hsync_b, vsync_b, valid_b;
    logic [7:0]  r_b, g_b, b_b;

    int checks = 0;
    int errors = 0;
    int t = 0;

    always #5 pclk = ~pclk;

    vga_ctrl dut_a (
        .pclk(pclk), .reset(reset), .vga_data(data_a),
        .h_addr(h_addr_a), .v_addr(v_addr_a),
        .hsync(hsync_a), .vsync(vsync_a), .valid(valid_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
    );

    vga_ctrl #(
        .h_size(8), .v_size(4), .h_sync(2), .h_back(3), .h_front(1),
        .v_sync(1), .v_back(2), .v_front(1)
    ) dut_b (
        .pclk(pclk), .reset(reset), .vga_data(data_b),
        .h_addr(h_addr_b), .v_addr(v_addr_b),
        .hsync(hsync_b), .vsync(vsync_b), .valid(valid_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
    );

    typedef struct {
        bit hs;
        bit vs;
        bit vld;
        int ha;
        int va;
    } exp_t;

    typedef struct {
        int          tt;
        bit          hs;
        bit          vs;
        bit          vld;
        int          ha;
        int          va;
        logic [23:0] rgb;
    } vec_t;

    // Raster position derived purely from elapsed cycles since reset release.
    function automatic exp_t model(int tt, int hsz, int vsz, int hsy, int hbk, int hfr,
                                   int vsy, int vbk, int vfr);
        exp_t m;
        int ht = hsy + hbk + hsz + hfr;
        int vt = vsy + vbk + vsz + vfr;
        int h  = tt % ht;
        int v  = (tt / ht) % vt;
        int ha0 = hsy + hbk;
        int va0 = vsy + vbk;
        bit hact = (h >= ha0) && (h < ha0 + hsz);
        bit vact = (v >= va0) && (v < va0 + vsz);
        m.hs  = (h >= hsy);
        m.vs  = (v >= vsy);
        m.vld = hact && vact;
        m.ha  = hact ? h - ha0 : 0;
        m.va  = vact ? v - va0 : 0;
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got %0h expected %0h", name, t, act, exp);
        end
    endtask

    task automatic check_zero();
        chk("rst_hsync_a", 32'(hsync_a), 0);
        chk("rst_vsync_a", 32'(vsync_a), 0);
        chk("rst_valid_a", 32'(valid_a), 0);
        chk("rst_haddr_a", 32'(h_addr_a), 0);
        chk("rst_vaddr_a", 32'(v_addr_a), 0);
        chk("rst_rgb_a", 32'({r_a, g_a, b_a}), 0);
        chk("rst_hsync_b", 32'(hsync_b), 0);
        chk("rst_vsync_b", 32'(vsync_b), 0);
        chk("rst_valid_b", 32'(valid_b), 0);
        chk("rst_rgb_b", 32'({r_b, g_b, b_b}), 0);
    endtask

    task automatic check_cycle();
        exp_t ea, eb;
        ea = model(t, 640, 480, 96, 48, 16, 2, 33, 10);
        eb = model(t, 8, 4, 2, 3, 1, 1, 2, 1);
        chk("hsync_a", 32'(hsync_a), 32'(ea.hs));
        chk("vsync_a", 32'(vsync_a), 32'(ea.vs));
        chk("valid_a", 32'(valid_a), 32'(ea.vld));
        chk("haddr_a", 32'(h_addr_a), 32'(ea.ha));
        chk("vaddr_a", 32'(v_addr_a), 32'(ea.va));
        chk("rgb_a", 32'({r_a, g_a, b_a}), ea.vld ? 32'(data_a) : 0);
        chk("hsync_b", 32'(hsync_b), 32'(eb.hs));
        chk("vsync_b", 32'(vsync_b), 32'(eb.vs));
        chk("valid_b", 32'(valid_b), 32'(eb.vld));
        chk("haddr_b", 32'(h_addr_b), 32'(eb.ha));
        chk("vaddr_b", 32'(v_addr_b), 32'(eb.va));
        chk("rgb_b", 32'({r_b, g_b, b_b}), eb.vld ? 32'(data_b) : 0);
    endtask

    initial begin
        vec_t tab[$];
        int   vi = 0;
        int   hs_low = 0;
        int   vld_b_cnt = 0;
        int   vld_a_first = -1;

        // hand-computed checkpoints for the default 640x480 timing, constant pixel data
        tab.push_back('{0,     0, 0, 0, 0,   0, 24'h000000});
        tab.push_back('{95,    0, 0, 0, 0,   0, 24'h000000});
        tab.push_back('{96,    1, 0, 0, 0,   0, 24'h000000});
        tab.push_back('{1599,  1, 0, 0, 0,   0, 24'h000000});
        tab.push_back('{1600,  0, 1, 0, 0,   0, 24'h000000});
        tab.push_back('{28143, 1, 1, 0, 0,   0, 24'h000000});
        tab.push_back('{28144, 1, 1, 1, 0,   0, 24'hA5C3F0});
        tab.push_back('{28145, 1, 1, 1, 1,   0, 24'hA5C3F0});
        tab.push_back('{28783, 1, 1, 1, 639, 0, 24'hA5C3F0});
        tab.push_back('{28784, 1, 1, 0, 0,   0, 24'h000000});
        tab.push_back('{28949, 1, 1, 1, 5,   1, 24'hA5C3F0});

        reset  = 1'b1;
        data_a = 24'hA5C3F0;
        data_b = 24'h5A5A5A;
        repeat (5) begin
            @(posedge pclk);
            #3;
            check_zero();
        end

        reset = 1'b0;
        t = 0;
        for (int n = 0; n <= 29100; n++) begin
            if (n > 0) begin
                @(posedge pclk);
                #2;
                data_a = (t < 29000) ? 24'hA5C3F0 : 24'($urandom);
                data_b = 24'($urandom);
                #1;
            end else begin
                #1;
            end
            t = n;
            check_cycle();
            while (vi < tab.size() && tab[vi].tt == t) begin
                chk("tab_hsync", 32'(hsync_a), 32'(tab[vi].hs));
                chk("tab_vsync", 32'(vsync_a), 32'(tab[vi].vs));
                chk("tab_valid", 32'(valid_a), 32'(tab[vi].vld));
                chk("tab_haddr", 32'(h_addr_a), 32'(tab[vi].ha));
                chk("tab_vaddr", 32'(v_addr_a), 32'(tab[vi].va));
                chk("tab_rgb", 32'({r_a, g_a, b_a}), 32'(tab[vi].rgb));
                vi++;
            end
            if (t < 800 && hsync_a === 1'b0) hs_low++;
            if (t < 1120 && valid_b === 1'b1) vld_b_cnt++;
        end
        chk("tab_all_applied", 32'(vi), 32'(tab.size()));
        chk("hsync_low_width", 32'(hs_low), 96);
        chk("small_valid_10_frames", 32'(vld_b_cnt), 320);

        // mid-frame reset at v_cnt=36, h_cnt=300: restart at (0,0) without recovery
        reset = 1'b1;
        @(posedge pclk);
        #3;
        check_zero();
        reset = 1'b0;
        for (int n = 0; n <= 28150; n++) begin
            if (n > 0) begin
                @(posedge pclk);
                #2;
                data_a = 24'($urandom);
                data_b = 24'($urandom);
                #1;
            end else begin
                #1;
            end
            t = n;
            check_cycle();
            if (vld_a_first < 0 && valid_a === 1'b1) vld_a_first = t;
        end
        chk("first_valid_after_midreset", 32'(vld_a_first), 28144);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
